// File: rtl/can_rx_frame_streamer.sv
// Buffers complete CAN frames from the protocol core and streams each one
// to the AXI controller as one or two 32-bit words with a registered
// valid/last handshake. Frames that arrive while the buffer is full are
// dropped and counted.
module can_rx_frame_streamer #(
    parameter int FRAME_DEPTH = 4,
    parameter int CNT_W       = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         frm_valid,
    input  logic [28:0]                  frm_id,
    input  logic                         frm_ide,
    input  logic                         frm_rtr,
    input  logic [3:0]                   frm_dlc,
    input  logic [63:0]                  frm_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic                         rx_last,
    output logic [31:0]                  rx_data,
    output logic [28:0]                  rx_id,
    output logic                         rx_ide,
    input  logic                         ovf_clr,
    output logic                         ovf_sticky,
    output logic [CNT_W-1:0]             drop_cnt,
    output logic [$clog2(FRAME_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FRAME_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic        two_words;
        logic [63:0] data;
    } frame_t;

    typedef enum logic {IDLE, SEND} state_t;

    frame_t     fifo_mem [FRAME_DEPTH];
    frame_t     in_frame;
    frame_t     head;
    logic [3:0] eff_len;
    logic       push;
    logic       pop;
    logic       drop;

    state_t           state_q,    state_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [LVL_W-1:0] level_q,    level_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_last_q,  rx_last_d;
    logic [31:0]      rx_data_q,  rx_data_d;
    logic [28:0]      rx_id_q,    rx_id_d;
    logic             rx_ide_q,   rx_ide_d;
    logic [31:0]      word1_q,    word1_d;
    logic             ovf_q,      ovf_d;
    logic [CNT_W-1:0] drop_q,     drop_d;

    // Clamp the length, zero bytes beyond it and decide the word count.
    always_comb begin
        // NOTE: combinational blocks assign every output first, so no path leaves a value unassigned and no latch is inferred.
        in_frame = '0;
        if (frm_rtr)
            eff_len = 4'd0;
        else if (frm_dlc > 4'd8)
            eff_len = 4'd8;
        else
            eff_len = frm_dlc;
        for (int i = 0; i < 8; i++) begin
            in_frame.data[i*8 +: 8] = (4'(i) < eff_len) ? frm_data[i*8 +: 8] : 8'h00;
        end
        in_frame.id        = frm_id;
        in_frame.ide       = frm_ide;
        in_frame.two_words = (eff_len > 4'd4);
    end

    assign head = fifo_mem[rd_ptr_q];

    // Frame storage; a push writes the tail slot.
    always_ff @(posedge ap_clk) begin
        // NOTE: the frame array is deliberately not reset; the level counter alone marks which slots are valid.
        if (push)
            fifo_mem[wr_ptr_q] <= in_frame;
    end

    // Next-state logic for the FIFO, the output stage and the drop counter.
    always_comb begin
        // NOTE: blocking '=' is used here so later lines see earlier results (pop feeds push); state registers use '<='.
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        rx_valid_d = rx_valid_q;
        rx_last_d  = rx_last_q;
        rx_data_d  = rx_data_q;
        rx_id_d    = rx_id_q;
        rx_ide_d   = rx_ide_q;
        word1_d    = word1_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        pop        = 1'b0;

        // A pop happens when the output register is free or finishes its last word.
        if (level_q != '0) begin
            if (state_q == IDLE)
                pop = 1'b1;
            else if (rx_valid_q && rx_ready && rx_last_q)
                pop = 1'b1;
        end

        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push = frm_valid && ((level_q < LVL_W'(FRAME_DEPTH)) || pop);
        drop = frm_valid && !push;

        if (pop) begin
            rx_valid_d = 1'b1;
            rx_last_d  = !head.two_words;
            rx_data_d  = head.data[31:0];
            word1_d    = head.data[63:32];
            rx_id_d    = head.id;
            rx_ide_d   = head.ide;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            state_d    = SEND;
        end else if (state_q == SEND && rx_valid_q && rx_ready) begin
            if (!rx_last_q) begin
                rx_data_d = word1_q;
                rx_last_d = 1'b1;
            end else begin
                rx_valid_d = 1'b0;
                rx_last_d  = 1'b0;
                state_d    = IDLE;
            end
        end

        if (push)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (push && !pop)
            level_d = level_q + LVL_W'(1);
        else if (pop && !push)
            level_d = level_q - LVL_W'(1);

        // A drop takes priority over a clear in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr)
                drop_d = CNT_W'(1);
            else if (drop_q != '1)
                drop_d = drop_q + CNT_W'(1);
        end else if (ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_last_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_id_q    <= '0;
            rx_ide_q   <= 1'b0;
            word1_q    <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            rx_valid_q <= rx_valid_d;
            rx_last_q  <= rx_last_d;
            rx_data_q  <= rx_data_d;
            rx_id_q    <= rx_id_d;
            rx_ide_q   <= rx_ide_d;
            word1_q    <= word1_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    assign rx_valid   = rx_valid_q;
    assign rx_last    = rx_last_q;
    assign rx_data    = rx_data_q;
    assign rx_id      = rx_id_q;
    assign rx_ide     = rx_ide_q;
    assign ovf_sticky = ovf_q;
    assign drop_cnt   = drop_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_can_rx_frame_streamer.sv
// Directed testbench for can_rx_frame_streamer with hand-computed expectations.
module tb_can_rx_frame_streamer;

    localparam logic [63:0] D = 64'h8877665544332211;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        frm_valid = 1'b0;
    logic [28:0] frm_id = '0;
    logic        frm_ide = 1'b0;
    logic        frm_rtr = 1'b0;
    logic [3:0]  frm_dlc = '0;
    logic [63:0] frm_data = '0;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        rx_last;
    logic [31:0] rx_data;
    logic [28:0] rx_id;
    logic        rx_ide;
    logic        ovf_clr = 1'b0;
    logic        ovf_sticky;
    logic [7:0]  drop_cnt;
    logic [2:0]  fifo_level;

    int n_asserts = 0;
    int n_fail    = 0;

    can_rx_frame_streamer #(.FRAME_DEPTH(4), .CNT_W(8)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .frm_valid  (frm_valid),
        .frm_id     (frm_id),
        .frm_ide    (frm_ide),
        .frm_rtr    (frm_rtr),
        .frm_dlc    (frm_dlc),
        .frm_data   (frm_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_last    (rx_last),
        .rx_data    (rx_data),
        .rx_id      (rx_id),
        .rx_ide     (rx_ide),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Present a frame for exactly one cycle.
    task automatic strobe(input logic [28:0] id, input logic ide, input logic rtr,
                          input logic [3:0] dlc, input logic [63:0] data);
        frm_id    = id;
        frm_ide   = ide;
        frm_rtr   = rtr;
        frm_dlc   = dlc;
        frm_data  = data;
        frm_valid = 1'b1;
        tick();
        frm_valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] data,
                              input logic last, input logic [28:0] id);
        check({tag, ".valid"}, 64'(rx_valid), 64'(1'b1));
        check({tag, ".data"},  64'(rx_data),  64'(data));
        check({tag, ".last"},  64'(rx_last),  64'(last));
        check({tag, ".id"},    64'(rx_id),    64'(id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst.valid", 64'(rx_valid), 0);
        check("rst.last",  64'(rx_last), 0);
        check("rst.data",  64'(rx_data), 0);
        check("rst.id",    64'(rx_id), 0);
        check("rst.ide",   64'(rx_ide), 0);
        check("rst.ovf",   64'(ovf_sticky), 0);
        check("rst.drop",  64'(drop_cnt), 0);
        check("rst.level", 64'(fifo_level), 0);
        ap_rst = 1'b0;
        tick();

        // Single 3-byte frame: valid two cycles after the strobe
        rx_ready = 1'b1;
        strobe(29'h123, 1'b0, 1'b0, 4'd3, D);
        check("single.lat1", 64'(rx_valid), 0);
        tick();
        check_word("single", 32'h00332211, 1'b1, 29'h123);
        check("single.ide", 64'(rx_ide), 0);
        tick();
        check("single.done", 64'(rx_valid), 0);
        check("single.hold", 64'(rx_data), 64'h00332211);

        // Extended 8-byte frame with a 3-cycle stall
        rx_ready = 1'b0;
        strobe(29'h1ABCDEF0, 1'b1, 1'b0, 4'd8, D);
        tick();
        check_word("ext.w0", 32'h44332211, 1'b0, 29'h1ABCDEF0);
        check("ext.ide", 64'(rx_ide), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_word("ext.stall", 32'h44332211, 1'b0, 29'h1ABCDEF0);
        end
        rx_ready = 1'b1;
        tick();
        check_word("ext.w1", 32'h88776655, 1'b1, 29'h1ABCDEF0);
        check("ext.ide1", 64'(rx_ide), 1);
        tick();
        check("ext.done", 64'(rx_valid), 0);

        // RTR frame gives a single zero word; DLC 15 behaves as 8
        strobe(29'h055, 1'b0, 1'b1, 4'd8, D);
        tick();
        check_word("rtr", 32'h00000000, 1'b1, 29'h055);
        tick();
        check("rtr.done", 64'(rx_valid), 0);
        strobe(29'h066, 1'b0, 1'b0, 4'd15, D);
        tick();
        check_word("dlc15.w0", 32'h44332211, 1'b0, 29'h066);
        tick();
        check_word("dlc15.w1", 32'h88776655, 1'b1, 29'h066);
        tick();
        check("dlc15.done", 64'(rx_valid), 0);

        // Overflow: six consecutive frames with the consumer stalled
        rx_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            strobe(29'(i), 1'b0, 1'b0, 4'd2, 64'(i));
        end
        check("ovf.drop",  64'(drop_cnt), 1);
        check("ovf.flag",  64'(ovf_sticky), 1);
        check("ovf.level", 64'(fifo_level), 4);
        check_word("ovf.head", 32'h1, 1'b1, 29'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr.drop", 64'(drop_cnt), 0);
        check("clr.flag", 64'(ovf_sticky), 0);

        // Drop coinciding with a clear: the drop wins
        ovf_clr = 1'b1;
        strobe(29'd7, 1'b0, 1'b0, 4'd2, 64'd7);
        ovf_clr = 1'b0;
        check("dropclr.drop",  64'(drop_cnt), 1);
        check("dropclr.flag",  64'(ovf_sticky), 1);
        check("dropclr.level", 64'(fifo_level), 4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr2.drop", 64'(drop_cnt), 0);

        // Drain the five kept frames back to back
        rx_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            check_word("drain", 32'(k), 1'b1, 29'(k));
            check("drain.level", 64'(fifo_level), 64'(5 - k));
        end
        tick();
        check("drain.done", 64'(rx_valid), 0);

        // Back-to-back drain of frames with dlc 2, 6, 0
        rx_ready = 1'b0;
        strobe(29'h10, 1'b0, 1'b0, 4'd2, D);
        strobe(29'h11, 1'b0, 1'b0, 4'd6, D);
        strobe(29'h12, 1'b0, 1'b0, 4'd0, D);
        check("b2b.level", 64'(fifo_level), 2);
        check_word("b2b.a", 32'h00002211, 1'b1, 29'h10);
        rx_ready = 1'b1;
        tick();
        check_word("b2b.b0", 32'h44332211, 1'b0, 29'h11);
        tick();
        check_word("b2b.b1", 32'h00006655, 1'b1, 29'h11);
        tick();
        check_word("b2b.c", 32'h00000000, 1'b1, 29'h12);
        tick();
        check("b2b.done", 64'(rx_valid), 0);

        // Reset while a two-word frame is pending and two frames are queued
        rx_ready = 1'b0;
        strobe(29'h20, 1'b0, 1'b0, 4'd8, D);
        strobe(29'h21, 1'b0, 1'b0, 4'd8, D);
        strobe(29'h22, 1'b0, 1'b0, 4'd8, D);
        check("mid.level", 64'(fifo_level), 2);
        check_word("mid.w0", 32'h44332211, 1'b0, 29'h20);
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        check("mid.valid", 64'(rx_valid), 0);
        check("mid.level0", 64'(fifo_level), 0);
        check("mid.last", 64'(rx_last), 0);
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid.quiet", 64'(rx_valid), 0);
        end
        strobe(29'h30, 1'b0, 1'b0, 4'd1, D);
        check("post.lat1", 64'(rx_valid), 0);
        tick();
        check_word("post", 32'h00000011, 1'b1, 29'h30);
        tick();
        check("post.done", 64'(rx_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/can_rx_frame_streamer.md
Name: can_rx_frame_streamer

Overview:
- Upstream neighbour of the CAN AXI controller's receive path.
- Captures complete frames strobed by the CAN protocol core (ID, IDE, RTR, DLC, 8 data bytes) into a small frame FIFO.
- Replays each frame as a 1–2 word stream on the controller-facing rx_valid/rx_last/rx_data/rx_id/rx_ide interface.
- Absorbs bursts while the controller is busy and counts frames dropped on overflow.

Parameters:
- FRAME_DEPTH, 4: number of buffered frames; power of two, ≥2.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- ap_clk  in  1  sole clock; everything is on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- frm_valid  in  1  single-cycle strobe: a frame is complete. There is no backpressure.
- frm_id  in  29  identifier; standard IDs are in [10:0], upper bits zero.
- frm_ide  in  1  extended-ID flag.
- frm_rtr  in  1  remote-frame flag.
- frm_dlc  in  4  data length code.
- frm_data  in  64  payload; byte0 is [7:0], byte7 is [63:56].
- rx_valid  out  1  output word valid.
- rx_ready  in  1  downstream accept; tie to 1 when the consumer is non-stalling.
- rx_last  out  1  final word of the frame.
- rx_data  out  32  payload word.
- rx_id  out  29  frame identifier; constant across all words of a frame.
- rx_ide  out  1  frame IDE flag; constant across all words of a frame.
- ovf_clr  in  1  clears ovf_sticky and drop_cnt.
- ovf_sticky  out  1  set when a frame has been dropped.
- drop_cnt  out  CNT_W  saturating count of dropped frames.
- fifo_level  out  clog2(FRAME_DEPTH)+1  number of stored frames, excluding the frame currently being streamed.

Behaviour:
- Reset:
  - FIFO pointers and level are 0; FSM is in IDLE.
  - rx_valid, rx_last, rx_data, rx_id, rx_ide, ovf_sticky and drop_cnt are all 0.
  - Reset mid-frame abandons the frame in flight and all buffered frames.
  - No partial word is emitted after reset.
- Length rules:
  - eff_len = (frm_rtr ? 0 : min(frm_dlc, 8)). A DLC of 9–15 is treated as 8.
  - eff_len 0–4 produces 1 word; eff_len 5–8 produces 2 words.
  - A zero-length or RTR frame still produces one word, with rx_data=0 and rx_last=1.
  - Bytes at index ≥ eff_len are forced to 0 when the frame is written into the FIFO.
  - word0 = masked[31:0]; word1 = masked[63:32].
- Push:
  - A frame is accepted when frm_valid=1 and either (fifo_level < FRAME_DEPTH) or a FIFO pop happens in the same cycle.
  - Otherwise the frame is dropped: ovf_sticky is set and drop_cnt increments, saturating at all-ones.
  - If ovf_clr and a drop occur in the same cycle, the drop wins: ovf_sticky=1 and drop_cnt=1.
- FSM (outputs are registered):
  - IDLE: when the FIFO is non-empty, pop the head entry. Load rx_id, rx_ide and word0, set rx_valid=1, set rx_last=(words==1). Go to SEND.
  - SEND, on rx_valid & rx_ready:
    - If rx_last=0: load word1, set rx_last=1, stay in SEND.
    - If rx_last=1 and the FIFO is non-empty: pop and load the next frame's word0 in the same cycle (back-to-back, no bubble), stay in SEND.
    - If rx_last=1 and the FIFO is empty: set rx_valid=0, rx_last=0 and go to IDLE. rx_data, rx_id and rx_ide hold their values.
  - SEND, without rx_valid & rx_ready: all outputs hold stable (AXI-stream rule).
- Latency: with an empty FIFO and the FSM in IDLE, frm_valid in cycle N gives rx_valid=1 in cycle N+2.
- Capacity: the FIFO holds FRAME_DEPTH frames plus the one held in the output register. A pop frees its slot for a push in the same cycle.
- fifo_level updates in the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- Pointers are clog2(FRAME_DEPTH) bits and wrap modulo FRAME_DEPTH. Full/empty is resolved by the level counter.

Test Plan:
- Single frame:
  - Stimulus: frm_id=0x123, ide=0, dlc=3, data=0x8877665544332211, rx_ready=1.
  - Required: exactly one word, rx_data=0x00332211, rx_last=1, rx_id=0x123, rx_ide=0, rx_valid high 2 cycles after the strobe.
- Extended 8-byte frame with stall:
  - Stimulus: id=0x1ABCDEF0, ide=1, dlc=8, data=0x8877665544332211; rx_ready low for 3 cycles.
  - Required: word0 0x44332211 (last=0) is held stable for all 3 stall cycles, then word1 0x88776655 (last=1); rx_id is constant on both words.
- RTR and DLC clamp:
  - Stimulus: an RTR frame with dlc=8, then a data frame with dlc=15.
  - Required: the RTR frame gives one word 0x00000000 (last=1); the dlc=15 frame gives two full words, the same as dlc=8.
- Overflow:
  - Stimulus: rx_ready=0; strobe 6 frames on consecutive cycles with FRAME_DEPTH=4.
  - Required: 5 frames are kept (4 in FIFO plus 1 in the output register); drop_cnt=1, ovf_sticky=1, fifo_level=4. Then ovf_clr clears both to 0.
- Back-to-back drain:
  - Stimulus: 3 queued frames (dlc 2, 6, 0), rx_ready=1.
  - Required: 4 words on consecutive cycles with no idle gaps; rx_last pattern 1,0,1,1.
- Reset mid-frame:
  - Stimulus: assert ap_rst while word0 of a 2-word frame is pending and 2 frames are queued.
  - Required: the next cycle has rx_valid=0, fifo_level=0 and no further words until a new strobe.
